// File: rtl/ptw_request_arbiter_pkg.sv
// Shared types for the PTW request arbiter: FSM states, owner encoding and bus widths.
package ptw_request_arbiter_pkg;

   localparam int VADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } ptw_arb_state_t;

   typedef enum logic {
      OWNER_DTLB,
      OWNER_ITLB
   } ptw_owner_t;

endpackage

// File: rtl/ptw_request_arbiter_if.sv
// TLB-side and PTW-side handshake bundle of the PTW request arbiter.
// slave = arbiter view, master = environment (TLBs + PTW) view.
interface ptw_request_arbiter_if;
   import ptw_request_arbiter_pkg::*;

   logic               itlb_req;
   logic [VADDR_W-1:0] itlb_vaddr;
   logic               dtlb_req;
   logic [VADDR_W-1:0] dtlb_vaddr;
   logic               dtlb_rnw;

   logic               ptw_req;
   logic [VADDR_W-1:0] ptw_vaddr;
   logic               ptw_rnw;
   logic               ptw_execute;
   logic               ptw_ack;
   logic               ptw_done;
   logic               ptw_is_fault;

   logic               itlb_write_entry;
   logic               itlb_is_fault;
   logic               dtlb_write_entry;
   logic               dtlb_is_fault;

   modport slave (
      input  itlb_req, itlb_vaddr, dtlb_req, dtlb_vaddr, dtlb_rnw,
      input  ptw_ack, ptw_done, ptw_is_fault,
      output ptw_req, ptw_vaddr, ptw_rnw, ptw_execute,
      output itlb_write_entry, itlb_is_fault, dtlb_write_entry, dtlb_is_fault
   );

   modport master (
      output itlb_req, itlb_vaddr, dtlb_req, dtlb_vaddr, dtlb_rnw,
      output ptw_ack, ptw_done, ptw_is_fault,
      input  ptw_req, ptw_vaddr, ptw_rnw, ptw_execute,
      input  itlb_write_entry, itlb_is_fault, dtlb_write_entry, dtlb_is_fault
   );

endinterface

// File: rtl/ptw_request_arbiter_grant_select.sv
// Combinational winner selection (DTLB-first with ITLB starvation guard) and
// the starve counter value to commit if this grant is taken.
module ptw_request_arbiter_grant_select
   import ptw_request_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                itlb_req,
   input  logic                dtlb_req,
   input  logic [STARVE_W-1:0] starve_cnt,
   output logic                grant_valid,
   output ptw_owner_t          grant_owner,
   output logic [STARVE_W-1:0] starve_cnt_next
);

   logic starved;
   assign starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));

   // NOTE: every output gets a default before the branches so no path leaves
   // a value unassigned, which would otherwise infer a latch.
   always_comb begin
      grant_valid     = itlb_req | dtlb_req;
      grant_owner     = OWNER_DTLB;
      starve_cnt_next = starve_cnt;
      if (itlb_req && (!dtlb_req || starved)) begin
         grant_owner     = OWNER_ITLB;
         starve_cnt_next = '0;
      end else if (dtlb_req && itlb_req) begin
         // Cannot overflow: at the limit the branch above forces ITLB.
         starve_cnt_next = starve_cnt + STARVE_W'(1);
      end
   end

endmodule

// File: rtl/ptw_request_arbiter.sv
// Shares one page-table walker between ITLB and DTLB; one walk outstanding at a time.
// Optional statistics counters are built when PTW_ARB_STATS_EN is defined.
module ptw_request_arbiter
   import ptw_request_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
`ifdef PTW_ARB_STATS_EN
   ,
   parameter int CNT_W        = 32
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sfence_valid,
   ptw_request_arbiter_if.slave   bus
`ifdef PTW_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]       stat_walks_i,
   output logic [CNT_W-1:0]       stat_walks_d,
   output logic [CNT_W-1:0]       stat_wait_cycles
`endif
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   ptw_arb_state_t     state, state_next;
   ptw_owner_t         owner;
   logic [VADDR_W-1:0] vaddr_q;
   logic               rnw_q;
   logic [STARVE_W-1:0] starve_cnt, starve_cnt_next, sel_starve_next;
   logic               abort, abort_next;
   logic               latch_grant;
   logic               sel_valid;
   ptw_owner_t         sel_owner;
   logic               owner_req;
   logic               walk_ok;

   ptw_request_arbiter_grant_select #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .STARVE_W     (STARVE_W)
   ) u_grant_select (
      .itlb_req        (bus.itlb_req),
      .dtlb_req        (bus.dtlb_req),
      .starve_cnt      (starve_cnt),
      .grant_valid     (sel_valid),
      .grant_owner     (sel_owner),
      .starve_cnt_next (sel_starve_next)
   );

   assign owner_req = (owner == OWNER_ITLB) ? bus.itlb_req : bus.dtlb_req;

   always_comb begin
      state_next      = state;
      abort_next      = abort;
      starve_cnt_next = starve_cnt;
      latch_grant     = 1'b0;
      case (state)
         IDLE: begin
            if (!sfence_valid && sel_valid) begin
               latch_grant     = 1'b1;
               starve_cnt_next = sel_starve_next;
               state_next      = ISSUE;
            end
         end
         ISSUE: begin
            // Once the PTW has accepted, the walk must be drained even if
            // cancelled in the same cycle, so ack takes priority over abort.
            if (bus.ptw_ack) begin
               state_next = WAIT;
               abort_next = sfence_valid | ~owner_req;
            end else if (sfence_valid || !owner_req) begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (bus.ptw_done) begin
               state_next = IDLE;
               abort_next = 1'b0;
            end else if (sfence_valid || !owner_req) begin
               abort_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= OWNER_DTLB;
         vaddr_q    <= '0;
         rnw_q      <= 1'b0;
         starve_cnt <= '0;
         abort      <= 1'b0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_cnt_next;
         abort      <= abort_next;
         if (latch_grant) begin
            owner   <= sel_owner;
            vaddr_q <= (sel_owner == OWNER_ITLB) ? bus.itlb_vaddr : bus.dtlb_vaddr;
            rnw_q   <= (sel_owner == OWNER_ITLB) ? 1'b1 : bus.dtlb_rnw;
         end
      end
   end

   assign bus.ptw_req     = (state == ISSUE);
   assign bus.ptw_vaddr   = vaddr_q;
   assign bus.ptw_rnw     = rnw_q;
   assign bus.ptw_execute = (owner == OWNER_ITLB);

   // Abort only reflects earlier cycles, so a same-cycle sfence still delivers.
   assign walk_ok = (state == WAIT) && bus.ptw_done && !abort;

   assign bus.itlb_write_entry = walk_ok && (owner == OWNER_ITLB) && !bus.ptw_is_fault;
   assign bus.itlb_is_fault    = walk_ok && (owner == OWNER_ITLB) &&  bus.ptw_is_fault;
   assign bus.dtlb_write_entry = walk_ok && (owner == OWNER_DTLB) && !bus.ptw_is_fault;
   assign bus.dtlb_is_fault    = walk_ok && (owner == OWNER_DTLB) &&  bus.ptw_is_fault;

`ifdef PTW_ARB_STATS_EN
   logic i_waiting, d_waiting;

   // A requester waits when it is neither being granted now nor owns the walk.
   assign i_waiting = bus.itlb_req
                    && !(latch_grant && sel_owner == OWNER_ITLB)
                    && !(state != IDLE && owner == OWNER_ITLB);
   assign d_waiting = bus.dtlb_req
                    && !(latch_grant && sel_owner == OWNER_DTLB)
                    && !(state != IDLE && owner == OWNER_DTLB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_walks_i     <= '0;
         stat_walks_d     <= '0;
         stat_wait_cycles <= '0;
      end else begin
         if (walk_ok && owner == OWNER_ITLB) stat_walks_i <= stat_walks_i + 1'b1;
         if (walk_ok && owner == OWNER_DTLB) stat_walks_d <= stat_walks_d + 1'b1;
         if (i_waiting || d_waiting)         stat_wait_cycles <= stat_wait_cycles + 1'b1;
      end
   end
`endif

   done_only_in_wait_a: assert property (@(posedge clk) disable iff (!rst_n)
      bus.ptw_done |-> state == WAIT);
   ack_only_in_issue_a: assert property (@(posedge clk) disable iff (!rst_n)
      bus.ptw_ack |-> state == ISSUE);

endmodule

// File: tb/tb_ptw_request_arbiter.sv
// Directed self-checking bench for ptw_request_arbiter (stats checks when PTW_ARB_STATS_EN).
module tb_ptw_request_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic sfence_valid;
   int   errors = 0;
   int   checks = 0;

   ptw_request_arbiter_if bus ();

`ifdef PTW_ARB_STATS_EN
   logic [31:0] stat_walks_i, stat_walks_d, stat_wait_cycles;
`endif

   ptw_request_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .sfence_valid     (sfence_valid),
      .bus              (bus)
`ifdef PTW_ARB_STATS_EN
      ,
      .stat_walks_i     (stat_walks_i),
      .stat_walks_d     (stat_walks_d),
      .stat_wait_cycles (stat_wait_cycles)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   // {itlb_write_entry, itlb_is_fault, dtlb_write_entry, dtlb_is_fault}
   function automatic logic [3:0] resp();
      return {bus.itlb_write_entry, bus.itlb_is_fault, bus.dtlb_write_entry, bus.dtlb_is_fault};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sfence_valid     = 1'b0;
      bus.itlb_req     = 1'b0;
      bus.itlb_vaddr   = '0;
      bus.dtlb_req     = 1'b0;
      bus.dtlb_vaddr   = '0;
      bus.dtlb_rnw     = 1'b0;
      bus.ptw_ack      = 1'b0;
      bus.ptw_done     = 1'b0;
      bus.ptw_is_fault = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_grant(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bus.ptw_req === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({bus.ptw_req, bus.ptw_rnw, bus.ptw_execute, resp()} !== 7'b0 || bus.ptw_vaddr !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%b rnw=%b exe=%b resp=%b vaddr=%h want all 0",
                  bus.ptw_req, bus.ptw_rnw, bus.ptw_execute, resp(), bus.ptw_vaddr);
      end
`ifdef PTW_ARB_STATS_EN
      checks++;
      if ({stat_walks_i, stat_walks_d, stat_wait_cycles} !== 96'h0) begin
         errors++;
         $display("FAIL reset_stats: got i=%0d d=%0d w=%0d want 0", stat_walks_i, stat_walks_d, stat_wait_cycles);
      end
`endif
   endtask

   task automatic test_dtlb_walk();
      apply_reset();
      bus.dtlb_vaddr = 32'h8000_1000;
      bus.dtlb_rnw   = 1'b0;
      bus.dtlb_req   = 1'b1;
      tick();
      checks++;
      if ({bus.ptw_req, bus.ptw_execute, bus.ptw_rnw} !== 3'b100 || bus.ptw_vaddr !== 32'h8000_1000) begin
         errors++;
         $display("FAIL dtlb_issue: got req=%b exe=%b rnw=%b vaddr=%h want 1 0 0 80001000",
                  bus.ptw_req, bus.ptw_execute, bus.ptw_rnw, bus.ptw_vaddr);
      end
      bus.ptw_ack = 1'b1;
      tick();
      bus.ptw_ack = 1'b0;
      checks++;
      if (bus.ptw_req !== 1'b0) begin
         errors++;
         $display("FAIL dtlb_req_after_ack: got %b want 0", bus.ptw_req);
      end
      bus.ptw_done = 1'b1;
      #1;
      checks++;
      if (resp() !== 4'b0010) begin
         errors++;
         $display("FAIL dtlb_fill_pulse: got %b want 0010", resp());
      end
      tick();
      bus.ptw_done = 1'b0;
      bus.dtlb_req = 1'b0;
      tick();
      checks++;
      if ({bus.ptw_req, resp()} !== 5'b0) begin
         errors++;
         $display("FAIL dtlb_after_done: got req=%b resp=%b want 0 0000", bus.ptw_req, resp());
      end
   endtask

   task automatic test_starvation();
      bit   seen;
      logic exp_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] exp_va;
      apply_reset();
      bus.itlb_vaddr = 32'h1000_0000;
      bus.dtlb_vaddr = 32'h2000_0000;
      bus.dtlb_rnw   = 1'b0;
      bus.itlb_req   = 1'b1;
      bus.dtlb_req   = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         wait_grant(seen);
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL starve_grant_timeout: walk %0d got no ptw_req want 1", k);
            break;
         end
         exp_va = exp_i[k] ? 32'h1000_0000 : 32'h2000_0000;
         checks++;
         if (bus.ptw_execute !== exp_i[k] || bus.ptw_rnw !== exp_i[k] || bus.ptw_vaddr !== exp_va) begin
            errors++;
            $display("FAIL starve_order: walk %0d got exe=%b rnw=%b vaddr=%h want exe=%b rnw=%b vaddr=%h",
                     k, bus.ptw_execute, bus.ptw_rnw, bus.ptw_vaddr, exp_i[k], exp_i[k], exp_va);
         end
         bus.ptw_ack = 1'b1;
         tick();
         bus.ptw_ack  = 1'b0;
         bus.ptw_done = 1'b1;
         #1;
         checks++;
         if (resp() !== (exp_i[k] ? 4'b1000 : 4'b0010)) begin
            errors++;
            $display("FAIL starve_resp: walk %0d got %b want %b", k, resp(), exp_i[k] ? 4'b1000 : 4'b0010);
         end
         tick();
         bus.ptw_done = 1'b0;
      end
      bus.itlb_req = 1'b0;
      bus.dtlb_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_itlb_fault();
      apply_reset();
      bus.itlb_vaddr = 32'h0040_2000;
      bus.itlb_req   = 1'b1;
      tick();
      checks++;
      if ({bus.ptw_req, bus.ptw_execute, bus.ptw_rnw} !== 3'b111 || bus.ptw_vaddr !== 32'h0040_2000) begin
         errors++;
         $display("FAIL itlb_issue: got req=%b exe=%b rnw=%b vaddr=%h want 1 1 1 00402000",
                  bus.ptw_req, bus.ptw_execute, bus.ptw_rnw, bus.ptw_vaddr);
      end
      bus.ptw_ack = 1'b1;
      tick();
      bus.ptw_ack      = 1'b0;
      bus.ptw_done     = 1'b1;
      bus.ptw_is_fault = 1'b1;
      #1;
      checks++;
      if (resp() !== 4'b0100) begin
         errors++;
         $display("FAIL itlb_fault_pulse: got %b want 0100", resp());
      end
      tick();
      bus.ptw_done     = 1'b0;
      bus.ptw_is_fault = 1'b0;
      bus.itlb_req     = 1'b0;
      tick();
   endtask

   task automatic test_sfence_abort();
      apply_reset();
      bus.dtlb_vaddr = 32'h8000_3000;
      bus.dtlb_req   = 1'b1;
      tick();
      bus.ptw_ack = 1'b1;
      tick();
      bus.ptw_ack  = 1'b0;
      sfence_valid = 1'b1;
      tick();
      sfence_valid = 1'b0;
      bus.ptw_done = 1'b1;
      #1;
      checks++;
      if (resp() !== 4'b0000) begin
         errors++;
         $display("FAIL abort_no_pulse: got %b want 0000", resp());
      end
      tick();
      bus.ptw_done = 1'b0;
      checks++;
      if (bus.ptw_req !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got ptw_req=%b want 0", bus.ptw_req);
      end
      tick();
      checks++;
      if (bus.ptw_req !== 1'b1 || bus.ptw_vaddr !== 32'h8000_3000) begin
         errors++;
         $display("FAIL abort_regrant: got req=%b vaddr=%h want 1 80003000", bus.ptw_req, bus.ptw_vaddr);
      end
      bus.ptw_ack = 1'b1;
      tick();
      bus.ptw_ack  = 1'b0;
      bus.ptw_done = 1'b1;
      #1;
      checks++;
      if (resp() !== 4'b0010) begin
         errors++;
         $display("FAIL abort_clears: got %b want 0010", resp());
      end
      tick();
      bus.ptw_done = 1'b0;
      bus.dtlb_req = 1'b0;
      tick();
   endtask

   task automatic test_sfence_with_done();
      apply_reset();
      bus.dtlb_vaddr = 32'h8000_4000;
      bus.dtlb_req   = 1'b1;
      tick();
      bus.ptw_ack = 1'b1;
      tick();
      bus.ptw_ack  = 1'b0;
      sfence_valid = 1'b1;
      bus.ptw_done = 1'b1;
      #1;
      checks++;
      if (resp() !== 4'b0010) begin
         errors++;
         $display("FAIL sfence_same_cycle: got %b want 0010", resp());
      end
      tick();
      sfence_valid = 1'b0;
      bus.ptw_done = 1'b0;
      bus.dtlb_req = 1'b0;
      tick();
   endtask

   task automatic test_withdraw_and_reset();
      apply_reset();
      bus.dtlb_vaddr = 32'h8000_5000;
      bus.dtlb_req   = 1'b1;
      tick();
      checks++;
      if (bus.ptw_req !== 1'b1) begin
         errors++;
         $display("FAIL withdraw_issue: got ptw_req=%b want 1", bus.ptw_req);
      end
      bus.dtlb_req = 1'b0;
      tick();
      checks++;
      if ({bus.ptw_req, resp()} !== 5'b0) begin
         errors++;
         $display("FAIL withdraw_drop: got req=%b resp=%b want 0 0000", bus.ptw_req, resp());
      end
      tick();
      checks++;
      if (bus.ptw_req !== 1'b0) begin
         errors++;
         $display("FAIL withdraw_no_regrant: got ptw_req=%b want 0", bus.ptw_req);
      end
      bus.itlb_vaddr = 32'h0070_6000;
      bus.itlb_req   = 1'b1;
      tick();
      bus.ptw_ack = 1'b1;
      tick();
      bus.ptw_ack = 1'b0;
      rst_n       = 1'b0;
      #1;
      checks++;
      if ({bus.ptw_req, bus.ptw_execute, bus.ptw_rnw} !== 3'b000 || bus.ptw_vaddr !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_walk: got req=%b exe=%b rnw=%b vaddr=%h want all 0",
                  bus.ptw_req, bus.ptw_execute, bus.ptw_rnw, bus.ptw_vaddr);
      end
      bus.ptw_done = 1'b1;
      #1;
      checks++;
      if (resp() !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid_walk_resp: got %b want 0000", resp());
      end
      bus.ptw_done = 1'b0;
      bus.itlb_req = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

`ifdef PTW_ARB_STATS_EN
   task automatic test_stats();
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         bus.dtlb_req = 1'b1;
         tick();
         bus.ptw_ack = 1'b1;
         tick();
         bus.ptw_ack  = 1'b0;
         bus.ptw_done = 1'b1;
         tick();
         bus.ptw_done = 1'b0;
         bus.dtlb_req = 1'b0;
         tick();
      end
      // Overlap: ITLB waits through the three cycles of the DTLB walk.
      bus.dtlb_req = 1'b1;
      bus.itlb_req = 1'b1;
      tick();
      bus.ptw_ack = 1'b1;
      tick();
      bus.ptw_ack  = 1'b0;
      bus.ptw_done = 1'b1;
      tick();
      bus.ptw_done = 1'b0;
      bus.dtlb_req = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         bus.itlb_req = 1'b1;
         if (k == 1) tick();
         bus.ptw_ack = 1'b1;
         tick();
         bus.ptw_ack  = 1'b0;
         bus.ptw_done = 1'b1;
         tick();
         bus.ptw_done = 1'b0;
         bus.itlb_req = 1'b0;
         tick();
      end
      bus.dtlb_req = 1'b1;
      tick();
      bus.ptw_ack = 1'b1;
      tick();
      bus.ptw_ack  = 1'b0;
      sfence_valid = 1'b1;
      tick();
      sfence_valid = 1'b0;
      bus.ptw_done = 1'b1;
      tick();
      bus.ptw_done = 1'b0;
      bus.dtlb_req = 1'b0;
      tick();
      checks++;
      if (stat_walks_d !== 32'd3 || stat_walks_i !== 32'd2) begin
         errors++;
         $display("FAIL stats_walks: got d=%0d i=%0d want d=3 i=2", stat_walks_d, stat_walks_i);
      end
      checks++;
      if (stat_wait_cycles !== 32'd3) begin
         errors++;
         $display("FAIL stats_wait: got %0d want 3", stat_wait_cycles);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_dtlb_walk();
      test_starvation();
      test_itlb_fault();
      test_sfence_abort();
      test_sfence_with_done();
      test_withdraw_and_reset();
`ifdef PTW_ARB_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
